// File: rtl/flag_write_ctrl.sv
// flag_write_ctrl: sequences and arbitrates all writes into the 8-bit Flag register.
// Optional: define FLAG_WRITE_CTRL_RR_EN for round-robin sw/alu arbitration.
module flag_write_ctrl #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [DW-1:0]          flag_cur,
    input  logic                   alu_req,
    input  logic [DW-1:0]          alu_flags,
    input  logic [DW-1:0]          alu_mask,
    input  logic                   sw_req,
    input  logic [DW-1:0]          sw_flags,
    input  logic                   save_req,
    input  logic                   restore_req,
    output logic                   alu_gnt,
    output logic                   sw_gnt,
    output logic                   save_ack,
    output logic                   restore_ack,
    output logic [DW-1:0]          Flagin,
    output logic                   wrflag,
    output logic [$clog2(DEPTH):0] stk_cnt,
    output logic                   stk_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] stk_mem [DEPTH];

    logic [DW-1:0] base;
    logic [DW-1:0] alu_val;
    logic [DW-1:0] merged;
    logic [DW-1:0] push_val;
    logic [DW-1:0] pop_val;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] pop_idx;
    logic          stk_empty;
    logic          stk_full;
    logic          sw_win;
    logic          wr_slot;
    logic          do_push;
    logic          do_pop;
    logic          stk_fault;

    // A write still sitting in Flagin has not reached the Flag register yet
    assign base    = wrflag ? Flagin : flag_cur;
    assign alu_val = (base & ~alu_mask) | (alu_flags & alu_mask);

    assign stk_empty = (stk_cnt == '0);
    assign stk_full  = (stk_cnt == CW'(DEPTH));
    assign push_idx  = AW'(stk_cnt);
    assign pop_idx   = AW'(stk_cnt - CW'(1));
    assign pop_val   = stk_mem[pop_idx];

`ifdef FLAG_WRITE_CTRL_RR_EN
    logic last_alu;

    // sw wins a collision only when the ALU took the previous grant
    assign sw_win = sw_req & (~alu_req | last_alu);

    // Remember which of sw/alu won most recently
    always_ff @(posedge CLK) begin
        if (Reset) begin
            last_alu <= 1'b1;
        end else if (alu_gnt) begin
            last_alu <= 1'b1;
        end else if (sw_gnt) begin
            last_alu <= 1'b0;
        end
    end
`else
    assign sw_win = sw_req;
`endif

    // Grant arbitration: restore first, then sw/alu; save rides alongside
    always_comb begin
        alu_gnt     = 1'b0;
        sw_gnt      = 1'b0;
        save_ack    = 1'b0;
        restore_ack = 1'b0;
        if (!Reset) begin
            restore_ack = restore_req;
            save_ack    = save_req & ~restore_req;
            sw_gnt      = ~restore_req & sw_win;
            alu_gnt     = ~restore_req & alu_req & ~sw_win;
        end
    end

    // Value the register will hold after this cycle and stack side effects
    always_comb begin
        merged    = sw_gnt ? sw_flags : alu_val;
        wr_slot   = sw_gnt | alu_gnt;
        push_val  = wr_slot ? merged : base;
        do_push   = save_ack & ~stk_full;
        do_pop    = restore_ack & ~stk_empty;
        stk_fault = (save_ack & stk_full) | (restore_ack & stk_empty);
    end

    // Flag register write port: one-cycle strobe with the merged value
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Flagin <= '0;
            wrflag <= 1'b0;
        end else if (do_pop) begin
            Flagin <= pop_val;
            wrflag <= 1'b1;
        end else if (wr_slot) begin
            Flagin <= merged;
            wrflag <= 1'b1;
        end else begin
            wrflag <= 1'b0;
        end
    end

    // Stack occupancy saturates at 0..DEPTH; misuse latches stk_err
    always_ff @(posedge CLK) begin
        if (Reset) begin
            stk_cnt <= '0;
            stk_err <= 1'b0;
        end else begin
            if (do_push) begin
                stk_cnt <= stk_cnt + CW'(1);
            end else if (do_pop) begin
                stk_cnt <= stk_cnt - CW'(1);
            end
            if (stk_fault) begin
                stk_err <= 1'b1;
            end
        end
    end

    // Shadow stack storage; contents are don't-care after reset
    always_ff @(posedge CLK) begin
        if (do_push) begin
            stk_mem[push_idx] <= push_val;
        end
    end

endmodule

// File: tb/tb_flag_write_ctrl.sv
// tb_flag_write_ctrl: directed and randomized checks of flag_write_ctrl
// against a queue-based model of the flag-write rules.
module tb_flag_write_ctrl;

    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic [DW-1:0] flag_cur = '0;
    logic          alu_req = 1'b0;
    logic [DW-1:0] alu_flags = '0;
    logic [DW-1:0] alu_mask = '0;
    logic          sw_req = 1'b0;
    logic [DW-1:0] sw_flags = '0;
    logic          save_req = 1'b0;
    logic          restore_req = 1'b0;
    logic          alu_gnt;
    logic          sw_gnt;
    logic          save_ack;
    logic          restore_ack;
    logic [DW-1:0] Flagin;
    logic          wrflag;
    logic [2:0]    stk_cnt;
    logic          stk_err;

    flag_write_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .CLK(CLK), .Reset(Reset), .flag_cur(flag_cur),
        .alu_req(alu_req), .alu_flags(alu_flags), .alu_mask(alu_mask),
        .sw_req(sw_req), .sw_flags(sw_flags),
        .save_req(save_req), .restore_req(restore_req),
        .alu_gnt(alu_gnt), .sw_gnt(sw_gnt),
        .save_ack(save_ack), .restore_ack(restore_ack),
        .Flagin(Flagin), .wrflag(wrflag),
        .stk_cnt(stk_cnt), .stk_err(stk_err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic [7:0] m_fin = '0;
    logic [7:0] m_reg = '0;
    logic       m_wr = 1'b0;
    logic       m_err = 1'b0;
    logic       m_last_alu = 1'b1;
    logic [7:0] q[$];
    bit         emu = 1'b0;

    // Per-cycle model expectations
    logic       e_alu, e_sw, e_sav, e_rst;
    logic       n_wr, n_err, n_pop, n_push;
    logic [7:0] n_fin, n_pushv;

    // Observed grants of the last cycle
    logic g_alu, g_sw, g_sav, g_rst;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
        n_checks++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, want);
    endtask

    task automatic model_comb();
        logic [7:0] b;
        logic [7:0] mv;
        bit sw_first;
        e_alu = 0; e_sw = 0; e_sav = 0; e_rst = 0;
        n_pop = 0; n_push = 0; n_pushv = '0;
        n_err = m_err; n_fin = m_fin; n_wr = 0;
        b = m_wr ? m_fin : flag_cur;
        mv = b;
`ifdef FLAG_WRITE_CTRL_RR_EN
        sw_first = m_last_alu;
`else
        sw_first = 1'b1;
`endif
        if (Reset) begin
            n_fin = '0;
            n_err = 1'b0;
        end else if (restore_req) begin
            e_rst = 1;
            if (q.size() > 0) begin
                n_pop = 1;
                n_fin = q[q.size()-1];
                n_wr = 1;
            end else begin
                n_err = 1;
            end
        end else begin
            if (sw_req && (!alu_req || sw_first)) begin
                e_sw = 1;
                mv = sw_flags;
            end else if (alu_req) begin
                e_alu = 1;
                mv = (b & ~alu_mask) | (alu_flags & alu_mask);
            end
            if (e_sw || e_alu) begin
                n_fin = mv;
                n_wr = 1;
            end
            if (save_req) begin
                e_sav = 1;
                if (q.size() == DEPTH) n_err = 1;
                else begin
                    n_push = 1;
                    n_pushv = n_wr ? mv : b;
                end
            end
        end
    endtask

    task automatic model_seq();
        if (m_wr) m_reg = m_fin;
        if (Reset) begin
            q.delete();
            m_last_alu = 1'b1;
        end else begin
            if (n_pop) void'(q.pop_back());
            if (n_push) q.push_back(n_pushv);
            if (e_alu) m_last_alu = 1'b1;
            else if (e_sw) m_last_alu = 1'b0;
        end
        m_fin = n_fin;
        m_wr  = n_wr;
        m_err = n_err;
    endtask

    // One clock: check grants before the edge, registers after it
    task automatic cycle();
        if (emu) flag_cur = m_reg;
        #1;
        model_comb();
        g_alu = alu_gnt; g_sw = sw_gnt;
        g_sav = save_ack; g_rst = restore_ack;
        chk("alu_gnt", alu_gnt, e_alu);
        chk("sw_gnt", sw_gnt, e_sw);
        chk("save_ack", save_ack, e_sav);
        chk("restore_ack", restore_ack, e_rst);
        @(posedge CLK);
        model_seq();
        #1;
        chk("Flagin", Flagin, m_fin);
        chk("wrflag", wrflag, m_wr);
        chk("stk_cnt", stk_cnt, q.size());
        chk("stk_err", stk_err, m_err);
    endtask

    task automatic idle();
        alu_req = 0; sw_req = 0; save_req = 0; restore_req = 0;
    endtask

    task automatic do_reset();
        idle();
        Reset = 1;
        cycle();
        Reset = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with every request raised: nothing granted
        Reset = 1;
        alu_req = 1; sw_req = 1; save_req = 1; restore_req = 1;
        cycle();
        chk("rst_gnts", {g_alu, g_sw, g_sav, g_rst}, 4'b0000);
        chk("rst_Flagin", Flagin, 8'h00);
        chk("rst_wrflag", wrflag, 1'b0);
        chk("rst_cnt", stk_cnt, 3'd0);
        chk("rst_err", stk_err, 1'b0);
        do_reset();

        // ALU masked write
        alu_req = 1; alu_flags = 8'hFF; alu_mask = 8'h0F; flag_cur = 8'h30;
        cycle();
        chk("t1_gnt", g_alu, 1'b1);
        chk("t1_Flagin", Flagin, 8'h3F);
        chk("t1_wrflag", wrflag, 1'b1);
        idle();
        cycle();
        chk("t1_wrflag_off", wrflag, 1'b0);

        // Forwarding of an uncaptured sw write into the ALU merge
        flag_cur = 8'h00;
        sw_req = 1; sw_flags = 8'hA0;
        cycle();
        sw_req = 0; alu_req = 1; alu_flags = 8'h01; alu_mask = 8'h01;
        cycle();
        chk("t2_Flagin", Flagin, 8'hA1);
        idle();
        cycle();

        // sw/alu collisions
        sw_req = 1; sw_flags = 8'h12;
        alu_req = 1; alu_flags = 8'h34; alu_mask = 8'hFF;
        cycle();
        chk("t3_sw_first", g_sw, 1'b1);
        chk("t3_alu_first", g_alu, 1'b0);
        sw_flags = 8'h56;
        cycle();
`ifdef FLAG_WRITE_CTRL_RR_EN
        chk("t3_rr_alu", g_alu, 1'b1);
        alu_req = 0;
        cycle();
        chk("t3_rr_sw", g_sw, 1'b1);
`else
        chk("t3_fix_sw", g_sw, 1'b1);
        sw_req = 0;
        cycle();
        chk("t3_fix_alu", g_alu, 1'b1);
`endif
        idle();
        cycle();

        // Save, ALU change, restore
        flag_cur = 8'h55;
        save_req = 1;
        cycle();
        chk("t4_cnt1", stk_cnt, 3'd1);
        save_req = 0; alu_req = 1; alu_flags = 8'h00; alu_mask = 8'hFF;
        cycle();
        alu_req = 0; flag_cur = 8'h00; restore_req = 1;
        cycle();
        chk("t4_ack", g_rst, 1'b1);
        chk("t4_Flagin", Flagin, 8'h55);
        chk("t4_wrflag", wrflag, 1'b1);
        chk("t4_cnt0", stk_cnt, 3'd0);

        // Overflow then underflow
        do_reset();
        save_req = 1;
        for (int i = 0; i < 4; i++) begin
            flag_cur = 8'(8'h10 + i);
            cycle();
        end
        chk("t5_full_err", stk_err, 1'b0);
        cycle();
        chk("t5_ovf_cnt", stk_cnt, 3'd4);
        chk("t5_ovf_err", stk_err, 1'b1);
        save_req = 0; restore_req = 1;
        for (int i = 0; i < 4; i++) cycle();
        chk("t5_last_pop", Flagin, 8'h10);
        cycle();
        chk("t5_unf_ack", g_rst, 1'b1);
        chk("t5_unf_wr", wrflag, 1'b0);
        chk("t5_unf_err", stk_err, 1'b1);
        chk("t5_unf_cnt", stk_cnt, 3'd0);

        // save + restore + sw together
        do_reset();
        flag_cur = 8'h77;
        save_req = 1;
        cycle();
        restore_req = 1; sw_req = 1; sw_flags = 8'hC3;
        cycle();
        chk("t6_only_rst", {g_alu, g_sw, g_sav, g_rst}, 4'b0001);
        chk("t6_cnt0", stk_cnt, 3'd0);
        restore_req = 0;
        cycle();
        chk("t6_save_sw", {g_sav, g_sw}, 2'b11);
        chk("t6_cnt1", stk_cnt, 3'd1);
        idle();
        restore_req = 1;
        cycle();
        chk("t6_pushed", Flagin, 8'hC3);

        // Randomized traffic with an emulated Flag register
        do_reset();
        emu = 1;
        for (int i = 0; i < 600; i++) begin
            Reset       = ($urandom_range(0, 79) == 0);
            restore_req = ($urandom_range(0, 5) == 0);
            save_req    = ($urandom_range(0, 3) == 0);
            sw_req      = ($urandom_range(0, 2) == 0);
            alu_req     = ($urandom_range(0, 1) == 0);
            sw_flags    = 8'($urandom);
            alu_flags   = 8'($urandom);
            alu_mask    = 8'($urandom);
            cycle();
        end
        Reset = 0;
        idle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flag_write_ctrl.md
Name: flag_write_ctrl

Overview:
Sequencer and arbiter for the 8-bit Flag register (ports Flagin/wrflag/Flagout).
- Arbitrates flag-write requests from the ALU, software flag-write instructions and the interrupt save/restore path.
- Applies per-bit write masks.
- Keeps a small shadow stack of flag values for interrupt entry/exit.
- Drives the Flag register's Flagin and wrflag; reads back its Flagout.

Parameters:
DEPTH, 4, shadow stack entries (power of two, 2..16)
DW, 8, flag width (matches Flag register)

Ports:
CLK  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
flag_cur  in  DW  Flag register Flagout
alu_req  in  1  ALU flag-update request, held until alu_gnt
alu_flags  in  DW  ALU flag values
alu_mask  in  DW  1 = bit written by ALU
sw_req  in  1  software flag-write request, held until sw_gnt
sw_flags  in  DW  software flag values (mask all-ones)
save_req  in  1  push current flags (interrupt entry)
restore_req  in  1  pop flags into register (interrupt exit)
alu_gnt  out  1  combinational grant, ALU write accepted this cycle
sw_gnt  out  1  combinational grant, software write accepted
save_ack  out  1  combinational, save accepted this cycle
restore_ack  out  1  combinational, restore accepted this cycle
Flagin  out  DW  registered value to Flag register
wrflag  out  1  registered write strobe to Flag register
stk_cnt  out  log2(DEPTH)+1  stack occupancy
stk_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (synchronous, active-high): Flagin=0, wrflag=0, stk_cnt=0, stk_err=0, stack contents don't-care.
- While Reset is high, all grants/acks are 0.
- Effective current value: base = wrflag ? Flagin : flag_cur. This forwards a write that the Flag register has not yet captured.
- Write-source priority: restore > sw > alu. At most one write source is granted per cycle.
- A losing requester sees gnt=0 and must keep req and data stable.
- Grant cycle: the next edge loads Flagin with the merged value and sets wrflag=1. Otherwise wrflag=0 and Flagin holds.
- Flag register captures on the following edge. Total latency req→Flagout = 2 edges.
- ALU merge: Flagin <= (base & ~alu_mask) | (alu_flags & alu_mask). A mask of 0 is still granted; it writes base back (no change).
- SW merge: Flagin <= sw_flags.
- Save:
  - Acked in any cycle where restore_req=0.
  - Pushes the value the register will hold after this cycle's write: the merged value if a sw/alu grant coexists, else base.
  - save with restore_req=1: restore wins, save_ack=0, save retries.
- Restore:
  - Acked when restore_req=1.
  - Stack non-empty: pops top, Flagin <= popped value, wrflag=1, stk_cnt-1.
  - Stack empty: no pop, no write (wrflag=0), stk_err<=1, still acked. sw/alu are not granted that cycle.
- Overflow: save when stk_cnt==DEPTH → acked, no push, stk_cnt unchanged, stk_err<=1.
- stk_cnt range is 0..DEPTH. Top pointer wraps never (saturating semantics above).
- stk_err clears only on Reset.
- Reset mid-operation: a pending wrflag is dropped on the reset edge; a request granted in the reset cycle is lost.

Optional Feature:
FLAG_WRITE_CTRL_RR_EN
- Defined: sw and alu arbitrate round-robin. A one-bit last-winner register (reset: alu last) gives the other source priority when both request. restore still has top priority.
- Undefined: fixed sw > alu priority as above.

Test Plan:
- Reset, then alu_req=1, alu_flags=8'hFF, alu_mask=8'h0F, flag_cur=8'h30 → alu_gnt same cycle; next edge Flagin=8'h3F, wrflag=1 for exactly one cycle.
- Back-to-back forwarding: sw write 8'hA0, then ALU mask 8'h01 flags 8'h01 on the next cycle with flag_cur still stale 8'h00 → second Flagin=8'hA1.
- sw_req and alu_req together → sw_gnt=1, alu_gnt=0; alu granted the following cycle. With FLAG_WRITE_CTRL_RR_EN, a second collision grants alu first.
- Save 8'h55 with flag_cur=8'h55; ALU changes flags to 8'h00; restore → restore_ack=1, Flagin=8'h55, wrflag=1, stk_cnt back to 0.
- DEPTH+1 saves → stk_cnt=4, stk_err=1 after the 5th. Then 5 restores → the 5th writes nothing, stk_err stays 1.
- save_req, restore_req and sw_req together with stk_cnt=1 → only restore_ack=1. The next cycle grants save_ack and sw_gnt together; the pushed value is sw_flags.
